window_scheduler: RTL and testbench

Sequencing controller for the face-detection classifier datapath. It walks a WIN×WIN detection window across each VGA frame in raster order with a fixed stride. For each window position it:
- streams the window's pixels into the classifier's row buffer, one column address per cycle;
- pulses a start to the classifier and waits for its done;
- accumulates the per-frame face count.

It sits between the frame buffer/VGA capture logic and the Classifier, and is the only block that drives the Classifier's ADDR input.

---
 rtl/window_scheduler_if.sv | 29 ++
 rtl/window_scheduler.sv | 138 +++++++++++++
 tb/tb_window_scheduler.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/window_scheduler_if.sv
// Handshake bundle between the window scheduler, the frame-buffer/capture side
// and the classifier. The master side is the scheduler itself.
interface window_scheduler_if;
   logic       frame_start;
   logic [9:0] rows_avail;
   logic       load_en;
   logic [8:0] addr;
   logic [4:0] load_row;
   logic [9:0] win_x;
   logic [9:0] win_y;
   logic       cls_start;
   logic       cls_done;
   logic       cls_face;
   logic [7:0] face_count;
   logic       busy;
   logic       frame_done;

   modport master (
      input  frame_start, rows_avail, cls_done, cls_face,
      output load_en, addr, load_row, win_x, win_y, cls_start,
             face_count, busy, frame_done
   );

   modport slave (
      output frame_start, rows_avail, cls_done, cls_face,
      input  load_en, addr, load_row, win_x, win_y, cls_start,
             face_count, busy, frame_done
   );
endinterface

// File: rtl/window_scheduler.sv
// Walks a WIN x WIN detection window over each frame in raster order, streams
// each window into the classifier, and counts faces per frame.
module window_scheduler #(
   parameter int FRAME_W = 640,
   parameter int FRAME_H = 480,
   parameter int WIN     = 20,
   parameter int STEP    = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   window_scheduler_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_ROWS, S_LOAD, S_START, S_WAIT_CLS, S_ADVANCE, S_DONE
   } state_t;

   // Position arithmetic is 11 bits wide so sums never overflow the compares.
   localparam logic [10:0] WIN_W     = 11'(WIN);
   localparam logic [10:0] STEP_W    = 11'(STEP);
   localparam logic [10:0] X_MAX     = 11'(FRAME_W - WIN);
   localparam logic [10:0] Y_MAX     = 11'(FRAME_H - WIN);
   localparam logic [8:0]  ADDR_LAST = 9'(WIN - 1);
   localparam logic [4:0]  ROW_LAST  = 5'(WIN - 1);

   state_t      state, state_nx;
   logic        load_en_nx, cls_start_nx, busy_nx, frame_done_nx;
   logic [8:0]  addr_nx;
   logic [4:0]  row_nx;
   logic [9:0]  x_nx, y_nx;
   logic [7:0]  count_nx;
   logic [10:0] x_step, y_step;

   assign x_step = {1'b0, bus.win_x} + STEP_W;
   assign y_step = {1'b0, bus.win_y} + STEP_W;

   always_comb begin
      // NOTE: every variable gets a default before any branch so no path can infer a latch.
      state_nx      = state;
      load_en_nx    = 1'b0;
      cls_start_nx  = 1'b0;
      frame_done_nx = 1'b0;
      addr_nx       = bus.addr;
      row_nx        = bus.load_row;
      x_nx          = bus.win_x;
      y_nx          = bus.win_y;
      count_nx      = bus.face_count;

      if (bus.frame_start) begin
         // A new frame always wins, including over a same-cycle verdict.
         state_nx = S_WAIT_ROWS;
         addr_nx  = '0;
         row_nx   = '0;
         x_nx     = '0;
         y_nx     = '0;
         count_nx = '0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: state_nx = S_IDLE;
            S_WAIT_ROWS: begin
               if ({1'b0, bus.rows_avail} >= {1'b0, bus.win_y} + WIN_W) begin
                  state_nx   = S_LOAD;
                  load_en_nx = 1'b1;
                  addr_nx    = '0;
                  row_nx     = '0;
               end
            end
            S_LOAD: begin
               if (bus.addr == ADDR_LAST) begin
                  addr_nx = '0;
                  if (bus.load_row == ROW_LAST) begin
                     state_nx     = S_START;
                     cls_start_nx = 1'b1;
                  end else begin
                     row_nx     = bus.load_row + 5'd1;
                     load_en_nx = 1'b1;
                  end
               end else begin
                  addr_nx    = bus.addr + 9'd1;
                  load_en_nx = 1'b1;
               end
            end
            S_START: state_nx = S_WAIT_CLS;
            S_WAIT_CLS: begin
               if (bus.cls_done) begin
                  if (bus.cls_face && bus.face_count != 8'hFF) count_nx = bus.face_count + 8'd1;
                  state_nx = S_ADVANCE;
               end
            end
            S_ADVANCE: begin
               if (x_step <= X_MAX) begin
                  x_nx     = x_step[9:0];
                  state_nx = S_WAIT_ROWS;
               end else if (y_step > Y_MAX) begin
                  // Past the last row: keep the final window position visible.
                  state_nx      = S_DONE;
                  frame_done_nx = 1'b1;
               end else begin
                  x_nx     = '0;
                  y_nx     = y_step[9:0];
                  state_nx = S_WAIT_ROWS;
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end

      busy_nx = !(state_nx inside {S_IDLE, S_DONE});
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         bus.load_en    <= 1'b0;
         bus.addr       <= '0;
         bus.load_row   <= '0;
         bus.win_x      <= '0;
         bus.win_y      <= '0;
         bus.cls_start  <= 1'b0;
         bus.face_count <= '0;
         bus.busy       <= 1'b0;
         bus.frame_done <= 1'b0;
      end else begin
         state          <= state_nx;
         bus.load_en    <= load_en_nx;
         bus.addr       <= addr_nx;
         bus.load_row   <= row_nx;
         bus.win_x      <= x_nx;
         bus.win_y      <= y_nx;
         bus.cls_start  <= cls_start_nx;
         bus.face_count <= count_nx;
         bus.busy       <= busy_nx;
         bus.frame_done <= frame_done_nx;
      end
   end

endmodule

// File: tb/tb_window_scheduler.sv
// Bench for window_scheduler: three parameterisations behind one stimulus mux,
// checked against a window-list / face-count model built from nested loops.
module tb_window_scheduler;

   typedef struct packed {
      logic       load_en;
      logic [8:0] addr;
      logic [4:0] load_row;
      logic [9:0] win_x;
      logic [9:0] win_y;
      logic       cls_start;
      logic [7:0] face_count;
      logic       busy;
      logic       frame_done;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       frame_start, cls_done, cls_face;
   logic [9:0] rows_avail;
   int         sel;
   obs_t       obs;
   int         checks = 0;
   int         errors = 0;
   int         n_cls_start = 0;
   int         n_frame_done = 0;

   always #5 clk = ~clk;

   window_scheduler_if bus_s ();
   window_scheduler_if bus_d ();
   window_scheduler_if bus_w ();

   window_scheduler #(.FRAME_W(40), .FRAME_H(24), .WIN(20), .STEP(4)) u_small (
      .clk(clk), .reset_n(reset_n), .bus(bus_s));
   window_scheduler u_default (
      .clk(clk), .reset_n(reset_n), .bus(bus_d));
   window_scheduler #(.FRAME_W(640), .FRAME_H(4), .WIN(2), .STEP(2)) u_wide (
      .clk(clk), .reset_n(reset_n), .bus(bus_w));

   assign bus_s.frame_start = frame_start && (sel == 0);
   assign bus_d.frame_start = frame_start && (sel == 1);
   assign bus_w.frame_start = frame_start && (sel == 2);
   assign bus_s.cls_done    = cls_done && (sel == 0);
   assign bus_d.cls_done    = cls_done && (sel == 1);
   assign bus_w.cls_done    = cls_done && (sel == 2);
   assign bus_s.cls_face    = cls_face;
   assign bus_d.cls_face    = cls_face;
   assign bus_w.cls_face    = cls_face;
   assign bus_s.rows_avail  = rows_avail;
   assign bus_d.rows_avail  = rows_avail;
   assign bus_w.rows_avail  = rows_avail;

   always_comb begin
      case (sel)
         0:       obs = {bus_s.load_en, bus_s.addr, bus_s.load_row, bus_s.win_x, bus_s.win_y,
                         bus_s.cls_start, bus_s.face_count, bus_s.busy, bus_s.frame_done};
         1:       obs = {bus_d.load_en, bus_d.addr, bus_d.load_row, bus_d.win_x, bus_d.win_y,
                         bus_d.cls_start, bus_d.face_count, bus_d.busy, bus_d.frame_done};
         default: obs = {bus_w.load_en, bus_w.addr, bus_w.load_row, bus_w.win_x, bus_w.win_y,
                         bus_w.cls_start, bus_w.face_count, bus_w.busy, bus_w.frame_done};
      endcase
   end

   // Pulse counters sample pre-edge values, like a register would.
   always @(posedge clk) begin
      if (obs.cls_start)  n_cls_start  <= n_cls_start + 1;
      if (obs.frame_done) n_frame_done <= n_frame_done + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Expects to be entered at the first load cycle of a window.
   task automatic check_window_loads(input int win, input int x, input int y, input bit spurious);
      for (int i = 0; i < win * win; i++) begin
         check("load_seq", 64'({obs.load_en, obs.addr, obs.load_row, obs.win_x, obs.win_y}),
               64'({1'b1, 9'(i % win), 5'(i / win), 10'(x), 10'(y)}));
         cls_done = spurious && ($urandom_range(0, 3) == 0);
         cls_face = 1'b1;
         step();
      end
      cls_done = 1'b0;
   endtask

   // Entered in the CLS_START cycle; leaves in the cycle after CLS_DONE.
   task automatic classify(input int lat, input bit face, inout int model_cnt);
      check("cls_start_high", 64'({obs.cls_start, obs.load_en}), 64'(2'b10));
      step();
      check("cls_start_low", 64'({obs.cls_start, obs.load_en}), 64'(2'b00));
      repeat (lat - 1) step();
      cls_done = 1'b1;
      cls_face = face;
      step();
      cls_done = 1'b0;
      cls_face = 1'b0;
      if (face && model_cnt < 255) model_cnt++;
      check("face_count", 64'(obs.face_count), 64'(model_cnt));
   endtask

   // face_mode: 0 never, 1 always, 2 random. lat <= 0 means random latency.
   task automatic run_frame(input int w, input int h, input int win, input int stp,
                            input int lat, input int face_mode);
      int xs[$];
      int ys[$];
      int cnt;
      int cs0;
      int fd0;
      bit face;
      int l;
      cnt = 0;
      for (int y = 0; y + win <= h; y += stp)
         for (int x = 0; x + win <= w; x += stp) begin
            xs.push_back(x);
            ys.push_back(y);
         end
      cs0 = n_cls_start;
      fd0 = n_frame_done;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("busy_after_start", 64'({obs.busy, obs.load_en, obs.face_count}), 64'({2'b10, 8'd0}));
      step();
      foreach (xs[k]) begin
         face = (face_mode == 1) ? 1'b1 : (face_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         l    = (lat > 0) ? lat : int'($urandom_range(1, 4));
         check_window_loads(win, xs[k], ys[k], 1'b0);
         classify(l, face, cnt);
         step();
         if (k == xs.size() - 1) begin
            check("frame_done", 64'({obs.frame_done, obs.busy, obs.win_x, obs.win_y}),
                  64'({2'b10, 10'(xs[k]), 10'(ys[k])}));
            step();
            check("frame_done_pulse", 64'({obs.frame_done, obs.busy}), 64'(2'b00));
         end else begin
            check("advance_pos", 64'({obs.win_x, obs.win_y, obs.load_en}),
                  64'({10'(xs[k + 1]), 10'(ys[k + 1]), 1'b0}));
            step();
         end
      end
      check("cls_start_count", 64'(n_cls_start - cs0), 64'(xs.size()));
      check("frame_done_count", 64'(n_frame_done - fd0), 64'(1));
      check("final_face_count", 64'(obs.face_count), 64'(cnt));
   endtask

   initial begin
      int cnt;
      int fd0;
      reset_n     = 1'b0;
      frame_start = 1'b0;
      cls_done    = 1'b0;
      cls_face    = 1'b0;
      rows_avail  = '0;
      sel         = 0;
      repeat (2) step();
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check("reset_state", 64'(obs), 64'(0));
      end
      reset_n = 1'b1;
      step();

      // Reset in the middle of a load, at ADDR = 7.
      sel        = 1;
      rows_avail = 10'd480;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
      check("first_load", 64'({obs.load_en, obs.addr}), 64'({1'b1, 9'd0}));
      repeat (7) step();
      check("mid_load_addr", 64'({obs.load_en, obs.addr}), 64'({1'b1, 9'd7}));
      reset_n = 1'b0;
      #1;
      check("async_reset", 64'(obs), 64'(0));
      step();
      reset_n = 1'b1;
      repeat (10) begin
         step();
         check("idle_after_reset", 64'({obs.load_en, obs.busy}), 64'(2'b00));
      end

      // Row gating with spurious CLS_DONE, then a face, then an abort with a same-cycle verdict.
      cnt        = 0;
      rows_avail = 10'd19;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      repeat (20) begin
         check("wait_rows", 64'({obs.busy, obs.load_en}), 64'(2'b10));
         cls_done = 1'($urandom_range(0, 1));
         cls_face = 1'b1;
         step();
      end
      cls_done   = 1'b0;
      rows_avail = 10'd20;
      step();
      check_window_loads(20, 0, 0, 1'b1);
      classify(2, 1'b1, cnt);
      step();
      check("advance_x", 64'({obs.win_x, obs.win_y, obs.load_en}), 64'({10'd4, 10'd0, 1'b0}));
      step();
      check_window_loads(20, 4, 0, 1'b1);
      check("cls_start_2", 64'(obs.cls_start), 64'(1));
      step();
      fd0         = n_frame_done;
      frame_start = 1'b1;
      cls_done    = 1'b1;
      cls_face    = 1'b1;
      rows_avail  = 10'd19;
      step();
      frame_start = 1'b0;
      cls_done    = 1'b0;
      check("abort", 64'({obs.face_count, obs.win_x, obs.win_y, obs.busy, obs.load_en,
                          obs.cls_start, obs.frame_done}),
            64'({8'd0, 10'd0, 10'd0, 4'b1000}));
      repeat (20) step();
      check("abort_no_frame_done", 64'(n_frame_done - fd0), 64'(0));
      check("abort_hold", 64'({obs.face_count, obs.busy, obs.load_en}), 64'({8'd0, 2'b10}));

      // Small frame: fixed latency of 3 with no faces, then a random frame.
      sel        = 0;
      rows_avail = 10'd24;
      run_frame(40, 24, 20, 4, 3, 0);
      run_frame(40, 24, 20, 4, 0, 2);

      // Wide strip with a face in every window drives the count into saturation.
      sel        = 2;
      rows_avail = 10'd4;
      run_frame(640, 4, 2, 2, 0, 1);
      check("saturated", 64'(obs.face_count), 64'(8'd255));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
